// File: rtl/turn_crossing_controller.sv
`default_nettype none
// ============================================================================
//  Module      : turn_crossing_controller
//  Description : Takes over the drivetrain when the line sensors report a
//                crossing, then carries out the pending route command
//                (straight, left, right, U-turn). Every phase is paced in
//                whole PWM frames taken from the shared timebase count.
//  Ports       : clk, reset_n              - clock, async active-low reset
//                enable                    - block armed; low returns to IDLE
//                sensor_l/m/r              - line sensors (1 = on line)
//                count_in[19:0]            - shared PWM timebase count
//                turn_cmd[1:0], turn_cmd_valid / turn_cmd_ready - command
//                count_reset               - timebase reset / frame boundary
//                motor_{l,r}_reset         - 1 = motor stopped
//                motor_{l,r}_direction     - 1 = forward
//                turn_crossing_start       - 1 = block owns the drivetrain
//                turn_done                 - completion pulse
//                fault                     - sticky rotate-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module turn_crossing_controller #(
  parameter int unsigned PERIOD_COUNT    = 1_000_000,
  parameter int unsigned CLEAR_FRAMES    = 15,
  parameter int unsigned MIN_TURN_FRAMES = 10,
  parameter int unsigned TIMEOUT_FRAMES  = 150,
  parameter int unsigned BRAKE_FRAMES    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sensor_l,
  input  logic        sensor_m,
  input  logic        sensor_r,
  input  logic [19:0] count_in,
  input  logic [1:0]  turn_cmd,
  input  logic        turn_cmd_valid,
  output logic        turn_cmd_ready,
  output logic        count_reset,
  output logic        motor_l_reset,
  output logic        motor_r_reset,
  output logic        motor_l_direction,
  output logic        motor_r_direction,
  output logic        turn_crossing_start,
  output logic        turn_done,
  output logic        fault
);

  localparam logic [19:0] c_TICK_COUNT = 20'(PERIOD_COUNT - 1);
  localparam logic [7:0]  c_CLEAR      = 8'(CLEAR_FRAMES);
  localparam logic [7:0]  c_MIN_TURN   = 8'(MIN_TURN_FRAMES);
  localparam logic [7:0]  c_TIMEOUT    = 8'(TIMEOUT_FRAMES);
  localparam logic [7:0]  c_BRAKE      = 8'(BRAKE_FRAMES);

  localparam logic [1:0]  c_CMD_STRAIGHT = 2'b00;
  localparam logic [1:0]  c_CMD_LEFT     = 2'b01;
  localparam logic [1:0]  c_CMD_UTURN    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BRAKE     = 3'd1,
    S_CLEAR     = 3'd2,
    S_ROT_LEAVE = 3'd3,
    S_ROT_SEEK  = 3'd4,
    S_FINISH    = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_frames;
  logic [1:0]  r_cmd;
  logic        r_pass;
  logic        r_fault;
  logic        r_boundary;
  logic        r_all_d;
  logic        r_armed;
  logic        r_ml_rst;
  logic        r_mr_rst;
  logic        r_ml_dir;
  logic        r_mr_dir;

  logic        w_all;
  logic        w_go;
  logic        w_tick;
  logic [7:0]  w_fr_eff;
  logic        w_ready;
  logic        w_done;
  logic        w_latch;
  logic        w_pass_set;
  logic        w_motor_load;
  logic        w_tgt_l_rst;
  logic        w_tgt_r_rst;
  logic        w_tgt_l_dir;
  logic        w_tgt_r_dir;

  assign w_all  = sensor_l & sensor_m & sensor_r;
  // Two consecutive 111 samples, and only after the sensors have left the
  // previous crossing, so one crossing cannot trigger twice.
  assign w_go   = enable & r_armed & w_all & r_all_d;
  assign w_tick = (r_state != S_IDLE) && (count_in == c_TICK_COUNT);

  // Frame count as it stands after this cycle's tick; every threshold test
  // uses it so a decision lands on the very tick that completes the frame.
  assign w_fr_eff = (w_tick && (r_frames != 8'hFF)) ? (r_frames + 8'd1) : r_frames;

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_done       = 1'b0;
    w_latch      = 1'b0;
    w_pass_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) w_state_next = S_BRAKE;
      end
      S_BRAKE: begin
        if (turn_cmd_valid && (w_fr_eff >= c_BRAKE)) begin
          w_state_next = S_CLEAR;
          w_ready      = 1'b1;
          w_latch      = 1'b1;
        end
      end
      S_CLEAR: begin
        if (w_fr_eff >= c_CLEAR)
          w_state_next = (r_cmd == c_CMD_STRAIGHT) ? S_FINISH : S_ROT_LEAVE;
      end
      S_ROT_LEAVE: begin
        if (w_tick && !sensor_m && (w_fr_eff >= 8'd1))
          w_state_next = S_ROT_SEEK;
        else if (w_fr_eff >= c_TIMEOUT)
          w_state_next = S_FAULT;
      end
      S_ROT_SEEK: begin
        if (w_tick && sensor_m && (w_fr_eff >= c_MIN_TURN)) begin
          // A U-turn sweeps past the line once before the real reacquire.
          if ((r_cmd == c_CMD_UTURN) && !r_pass) begin
            w_state_next = S_ROT_LEAVE;
            w_pass_set   = 1'b1;
          end else begin
            w_state_next = S_FINISH;
          end
        end else if (w_fr_eff >= c_TIMEOUT) begin
          w_state_next = S_FAULT;
        end
      end
      S_FINISH: begin
        if (w_fr_eff >= c_BRAKE) begin
          w_state_next = S_IDLE;
          w_done       = 1'b1;
        end
      end
      S_FAULT: begin
        w_state_next = S_FAULT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // Disarming overrides everything and suppresses completion/handshake.
    if ((r_state != S_IDLE) && !enable) begin
      w_state_next = S_IDLE;
      w_ready      = 1'b0;
      w_done       = 1'b0;
      w_latch      = 1'b0;
      w_pass_set   = 1'b0;
    end
  end

  // Motor pattern wanted for the state being entered/held.
  always_comb begin
    w_tgt_l_rst = 1'b1;
    w_tgt_r_rst = 1'b1;
    w_tgt_l_dir = 1'b1;
    w_tgt_r_dir = 1'b1;
    case (w_state_next)
      S_CLEAR: begin
        w_tgt_l_rst = 1'b0;
        w_tgt_r_rst = 1'b0;
      end
      S_ROT_LEAVE, S_ROT_SEEK: begin
        w_tgt_l_rst = 1'b0;
        w_tgt_r_rst = 1'b0;
        if (r_cmd == c_CMD_LEFT) w_tgt_l_dir = 1'b0;
        else                     w_tgt_r_dir = 1'b0;
      end
      default: begin
        w_tgt_l_rst = 1'b1;
        w_tgt_r_rst = 1'b1;
      end
    endcase
  end

  // Motors change only on frame boundaries, except the forced stop on
  // return to IDLE.
  assign w_motor_load = w_tick || ((r_state != S_IDLE) && (w_state_next == S_IDLE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_frames   <= 8'd0;
      r_cmd      <= 2'b00;
      r_pass     <= 1'b0;
      r_fault    <= 1'b0;
      r_boundary <= 1'b1;
      r_all_d    <= 1'b0;
      r_armed    <= 1'b0;
      r_ml_rst   <= 1'b1;
      r_mr_rst   <= 1'b1;
      r_ml_dir   <= 1'b1;
      r_mr_dir   <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_frames <= (w_state_next != r_state) ? 8'd0 : w_fr_eff;
      if (w_latch) r_cmd <= turn_cmd;
      if ((w_state_next == S_IDLE) || w_latch) r_pass <= 1'b0;
      else if (w_pass_set)                     r_pass <= 1'b1;
      if (w_state_next == S_FAULT) r_fault <= 1'b1;
      // Restart the timebase on the first cycle of a takeover.
      r_boundary <= (r_state == S_IDLE) && (w_state_next == S_BRAKE);
      r_all_d    <= w_all;
      if (r_state != S_IDLE) r_armed <= 1'b0;
      else if (!w_all)       r_armed <= 1'b1;
      if (w_motor_load) begin
        r_ml_rst <= w_tgt_l_rst;
        r_mr_rst <= w_tgt_r_rst;
        r_ml_dir <= w_tgt_l_dir;
        r_mr_dir <= w_tgt_r_dir;
      end
    end
  end

  assign count_reset         = r_boundary | w_tick;
  assign motor_l_reset       = r_ml_rst;
  assign motor_r_reset       = r_mr_rst;
  assign motor_l_direction   = r_ml_dir;
  assign motor_r_direction   = r_mr_dir;
  assign turn_crossing_start = (r_state != S_IDLE);
  assign turn_cmd_ready      = w_ready;
  assign turn_done           = w_done;
  assign fault               = r_fault;

endmodule
`default_nettype wire
